// File: rtl/pulse_measure.sv
// pulse_measure: measures high-pulse widths of an asynchronous input in clk cycles.
// Each pulse is classified as accepted (valid), too short or too long, and
// accepted pulses are counted.
// Optional macro PULSE_MEASURE_LOW_EN adds measurement of the low gap before each pulse.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   din          - asynchronous pulse input
//   width        - high time of last accepted pulse
//   valid        - strobe: width updated
//   too_short    - strobe: pulse shorter than MIN_LEN rejected
//   too_long     - strobe: pulse reached MAX_LEN
//   busy         - a pulse is being measured
//   pulse_count  - accepted pulse count (wraps)
//   low_width    - gap before last pulse (0 when feature disabled)
//   low_valid    - strobe: low_width updated (0 when feature disabled)
module pulse_measure #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned MIN_LEN     = 2,
  parameter int unsigned MAX_LEN     = 1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [WIDTH-1:0] width,
  output logic             valid,
  output logic             too_short,
  output logic             too_long,
  output logic             busy,
  output logic [WIDTH-1:0] pulse_count,
  output logic [WIDTH-1:0] low_width,
  output logic             low_valid
);

  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {ARM, IDLE, MEASURE, OVERRANGE} state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   din_s;
  logic [FILL_W-1:0]      fill;
  logic [WIDTH-1:0]       cnt, cnt_d, cnt_inc;
  logic [WIDTH-1:0]       width_d, pulse_count_d;
  logic                   valid_d, too_short_d, too_long_d, busy_d;

  assign din_s   = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt + WIDTH'(1);

  // Input synchronizer, plus a fill counter so ARM ignores the reset-cleared
  // synchronizer contents and only decides on real samples of din.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      fill   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (state == ARM && fill != FILL_W'(SYNC_STAGES)) fill <= fill + FILL_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ARM;
    else     state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ARM:       if (fill == FILL_W'(SYNC_STAGES) && !din_s) state_d = IDLE;
      IDLE:      if (din_s) state_d = (WIDTH'(1) >= WIDTH'(MAX_LEN)) ? OVERRANGE : MEASURE;
      MEASURE: begin
        if (!din_s)                         state_d = IDLE;
        else if (cnt_inc >= WIDTH'(MAX_LEN)) state_d = OVERRANGE;
      end
      OVERRANGE: if (!din_s) state_d = IDLE;
      default:   state_d = ARM;
    endcase
  end

  // Output / counter next values
  always_comb begin
    cnt_d         = cnt;
    width_d       = width;
    pulse_count_d = pulse_count;
    valid_d       = 1'b0;
    too_short_d   = 1'b0;
    too_long_d    = 1'b0;
    busy_d        = (state_d == MEASURE) || (state_d == OVERRANGE);
    case (state)
      IDLE: begin
        if (din_s) begin
          cnt_d      = WIDTH'(1);
          too_long_d = (state_d == OVERRANGE);
        end
      end
      MEASURE: begin
        if (din_s) begin
          cnt_d      = cnt_inc;
          too_long_d = (state_d == OVERRANGE);
        end else if (cnt < WIDTH'(MIN_LEN)) begin
          too_short_d = 1'b1;
        end else begin
          width_d       = cnt;
          valid_d       = 1'b1;
          pulse_count_d = pulse_count + WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      width       <= '0;
      pulse_count <= '0;
      valid       <= 1'b0;
      too_short   <= 1'b0;
      too_long    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cnt         <= cnt_d;
      width       <= width_d;
      pulse_count <= pulse_count_d;
      valid       <= valid_d;
      too_short   <= too_short_d;
      too_long    <= too_long_d;
      busy        <= busy_d;
    end
  end

`ifdef PULSE_MEASURE_LOW_EN
  logic [WIDTH-1:0] gap, gap_d, low_width_d;
  logic             gap_ok, gap_ok_d, low_valid_d;

  // Gap counter: starts at 1 on the first low sample (MEASURE/OVERRANGE -> IDLE),
  // saturates at MAX_LEN. gap_ok suppresses the gap seen right after ARM.
  always_comb begin
    gap_d       = gap;
    gap_ok_d    = gap_ok;
    low_width_d = low_width;
    low_valid_d = 1'b0;
    case (state)
      ARM: begin
        gap_d    = '0;
        gap_ok_d = 1'b0;
      end
      IDLE: begin
        if (din_s) begin
          if (gap_ok) begin
            low_width_d = gap;
            low_valid_d = 1'b1;
          end
        end else if (gap < WIDTH'(MAX_LEN)) begin
          gap_d = gap + WIDTH'(1);
        end
      end
      default: begin
        if (state_d == IDLE) begin
          gap_d    = WIDTH'(1);
          gap_ok_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap       <= '0;
      gap_ok    <= 1'b0;
      low_width <= '0;
      low_valid <= 1'b0;
    end else begin
      gap       <= gap_d;
      gap_ok    <= gap_ok_d;
      low_width <= low_width_d;
      low_valid <= low_valid_d;
    end
  end
`else
  assign low_width = '0;
  assign low_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_measure.sv
// Directed testbench for pulse_measure (WIDTH=8, MIN_LEN=2, MAX_LEN=20, SYNC_STAGES=2).
// din is driven 1 time unit after a rising edge; outputs are checked at the same point,
// so they reflect the edge just taken.
module tb_pulse_measure;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic [7:0] width, pulse_count, low_width;
  logic       valid, too_short, too_long, busy, low_valid;

  int n_assert = 0;
  int n_fail   = 0;

  // strobe / level event totals sampled on falling edges
  int n_valid = 0, n_short = 0, n_long = 0, n_busy = 0, n_low = 0, n_lw_nz = 0;
  int s_valid, s_short, s_long, s_busy, s_low;

  pulse_measure #(
    .WIDTH(8), .MIN_LEN(2), .MAX_LEN(20), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .din(din),
    .width(width), .valid(valid), .too_short(too_short), .too_long(too_long),
    .busy(busy), .pulse_count(pulse_count),
    .low_width(low_width), .low_valid(low_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid)     n_valid++;
    if (too_short) n_short++;
    if (too_long)  n_long++;
    if (busy)      n_busy++;
    if (low_valid) n_low++;
    if (low_width !== 8'd0) n_lw_nz++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_valid = n_valid; s_short = n_short; s_long = n_long; s_busy = n_busy; s_low = n_low;
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    tick(3);
    chk("rst width", 32'(width), 0);
    chk("rst count", 32'(pulse_count), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst strobes", 32'({valid, too_short, too_long, low_valid}), 0);
    rst = 1'b0;
    tick(6);

    // Test 1: 6-cycle pulse, valid 3 cycles after din falls
    snap();
    din = 1'b1; tick(6);
    din = 1'b0; tick(2);
    chk("t1 valid early", 32'(valid), 0);
    chk("t1 busy before", 32'(busy), 1);
    tick(1);
    chk("t1 valid", 32'(valid), 1);
    chk("t1 width", 32'(width), 6);
    chk("t1 count", 32'(pulse_count), 1);
    chk("t1 busy after", 32'(busy), 0);
    tick(3);
    chk("t1 valid strobes", 32'(n_valid - s_valid), 1);
    chk("t1 busy cycles", 32'(n_busy - s_busy), 6);

    // Test 2: 1-cycle pulse rejected
    snap();
    din = 1'b1; tick(1);
    din = 1'b0; tick(6);
    chk("t2 short strobes", 32'(n_short - s_short), 1);
    chk("t2 valid strobes", 32'(n_valid - s_valid), 0);
    chk("t2 width", 32'(width), 6);
    chk("t2 count", 32'(pulse_count), 1);

    // Test 3: 25-cycle pulse overranges at 20 cycles, then a 4-cycle pulse
    snap();
    din = 1'b1; tick(21);
    chk("t3 long early", 32'(too_long), 0);
    tick(1);
    chk("t3 too_long", 32'(too_long), 1);
    chk("t3 busy over", 32'(busy), 1);
    tick(1);
    chk("t3 long drop", 32'(too_long), 0);
    tick(2);
    din = 1'b0; tick(2);
    chk("t3 busy held", 32'(busy), 1);
    tick(1);
    chk("t3 busy drop", 32'(busy), 0);
    tick(2);
    chk("t3 long strobes", 32'(n_long - s_long), 1);
    chk("t3 valid strobes", 32'(n_valid - s_valid), 0);
    chk("t3 short strobes", 32'(n_short - s_short), 0);
    chk("t3 count", 32'(pulse_count), 1);
    din = 1'b1; tick(4);
    din = 1'b0; tick(5);
    chk("t3 width4", 32'(width), 4);
    chk("t3 count2", 32'(pulse_count), 2);

    // Test 4: pulse already high at reset release is ignored
    din = 1'b1; rst = 1'b1; tick(2);
    chk("t4 rst count", 32'(pulse_count), 0);
    chk("t4 rst width", 32'(width), 0);
    snap();
    rst = 1'b0; tick(10);
    din = 1'b0; tick(3);
    chk("t4 no strobe", 32'((n_valid - s_valid) + (n_short - s_short) + (n_long - s_long)), 0);
    din = 1'b1; tick(5);
    din = 1'b0; tick(6);
    chk("t4 valid strobes", 32'(n_valid - s_valid), 1);
    chk("t4 width", 32'(width), 5);
    chk("t4 count", 32'(pulse_count), 1);
    chk("t4 first gap hidden", 32'(n_low - s_low), 0);
    // reset in the middle of a pulse
    din = 1'b1; tick(4);
    chk("t4 busy mid", 32'(busy), 1);
    rst = 1'b1; tick(1);
    chk("t4 mid busy", 32'(busy), 0);
    chk("t4 mid width", 32'(width), 0);
    chk("t4 mid count", 32'(pulse_count), 0);
    chk("t4 mid strobes", 32'({valid, too_short, too_long, low_valid}), 0);
    chk("t4 mid low_width", 32'(low_width), 0);
    rst = 1'b0; din = 1'b0; tick(6);

    // Test 5: back-to-back pulses with 1-cycle gap, then count wrap
    snap();
    din = 1'b1; tick(3);
    din = 1'b0; tick(1);
    din = 1'b1; tick(2);
    chk("t5 valid a", 32'(valid), 1);
    chk("t5 width a", 32'(width), 3);
    tick(3);
    din = 1'b0; tick(3);
    chk("t5 valid b", 32'(valid), 1);
    chk("t5 width b", 32'(width), 5);
    chk("t5 count", 32'(pulse_count), 2);
    tick(2);
    for (int i = 0; i < 253; i++) begin
      din = 1'b1; tick(2);
      din = 1'b0; tick(1);
    end
    tick(4);
    chk("t5 count255", 32'(pulse_count), 255);
    chk("t5 valid strobes", 32'(n_valid - s_valid), 255);
    din = 1'b1; tick(2);
    din = 1'b0; tick(5);
    chk("t5 wrap", 32'(pulse_count), 0);
    chk("t5 width2", 32'(width), 2);

    // Test 6: low-time measurement
`ifdef PULSE_MEASURE_LOW_EN
    tick(25);
    din = 1'b1; tick(4);
    chk("t6 sat first", 32'(low_width), 20);
    snap();
    din = 1'b0; tick(7);
    din = 1'b1; tick(3);
    chk("t6 low_valid", 32'(low_valid), 1);
    chk("t6 low_width7", 32'(low_width), 7);
    chk("t6 busy rise", 32'(busy), 1);
    tick(1);
    chk("t6 low drop", 32'(low_valid), 0);
    tick(3);
    din = 1'b0; tick(30);
    din = 1'b1; tick(3);
    chk("t6 low_valid sat", 32'(low_valid), 1);
    chk("t6 low_width20", 32'(low_width), 20);
    tick(1);
    din = 1'b0; tick(6);
    chk("t6 low strobes", 32'(n_low - s_low), 2);
`else
    din = 1'b1; tick(4);
    din = 1'b0; tick(7);
    din = 1'b1; tick(4);
    din = 1'b0; tick(6);
    chk("t6 low_width zero", 32'(n_lw_nz), 0);
    chk("t6 low_valid zero", 32'(n_low), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
